// File: rtl/toggle_arb_pkg.sv
// Shared types and constants for the toggle arbiter and its round-robin picker.
package toggle_arb_pkg;

   // Arbiter control states; only these three are ever reachable.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      APPLY = 2'd2
   } state_t;

   localparam int DEF_NREQ = 4;
   localparam int DEF_W    = 8;
   localparam int CNT_W    = 8;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Increment that sticks at the all-ones value instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/toggle_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NREQ, returned as a one-hot vector.
module rr_pick
   import toggle_arb_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] winner,
   output logic            valid
);

   logic [NREQ-1:0] rot;
   logic [NREQ-1:0] rot_pick;
   logic            found;

   // Rotate requests so that position j holds requester (ptr + j) mod NREQ.
   always_comb begin
      rot = '0;
      for (int j = 0; j < NREQ; j++) begin
         for (int k = 0; k < NREQ; k++) begin
            if (k == (int'(ptr) + j) % NREQ) begin
               rot[j] = req[k];
            end
         end
      end
   end

   // Fixed-priority pick on the rotated vector: lowest position wins.
   always_comb begin
      rot_pick = '0;
      found    = 1'b0;
      for (int j = 0; j < NREQ; j++) begin
         if (!found && rot[j]) begin
            rot_pick[j] = 1'b1;
            found       = 1'b1;
         end
      end
   end

   // Undo the rotation so the one-hot lines up with the original requesters.
   always_comb begin
      winner = '0;
      for (int j = 0; j < NREQ; j++) begin
         for (int k = 0; k < NREQ; k++) begin
            if (k == (int'(ptr) + j) % NREQ) begin
               winner[k] = rot_pick[j];
            end
         end
      end
   end

   assign valid = |req;

endmodule

// File: rtl/toggle_arbiter.sv
// Round-robin arbiter granting requesters exclusive use of a shared bank of
// T flip-flops: each completed transaction XORs the winner's mask into q.
module toggle_arbiter
   import toggle_arb_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int W    = DEF_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] tmask,
   input  logic              hold,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   ack,
   output logic [W-1:0]      q,
   output logic              busy,
   output logic [CNT_W-1:0]  tog_cnt
);

   localparam int             PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [PW-1:0]  LAST_IDX = PW'(NREQ - 1);

   state_t            state_reg;
   logic [PW-1:0]     ptr_reg;
   logic [PW-1:0]     win_reg;
   logic [NREQ-1:0]   gnt_reg;
   logic [NREQ-1:0]   ack_reg;
   logic [W-1:0]      q_reg;
   logic [CNT_W-1:0]  cnt_reg;

   logic [NREQ-1:0]   pick_onehot;
   logic              pick_valid;
   logic [PW-1:0]     pick_idx;
   logic [W-1:0]      mask_arr [NREQ];

   // Split the flat mask bus into one slice per requester.
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
         assign mask_arr[gi] = tmask[gi*W +: W];
      end
   endgenerate

   rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_pick (
      .req    (req),
      .ptr    (ptr_reg),
      .winner (pick_onehot),
      .valid  (pick_valid)
   );

   // Encode the picker's one-hot result into an index for later lookups.
   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick_onehot[i]) begin
            pick_idx = PW'(i);
         end
      end
   end

   // Arbitration FSM: IDLE picks, GRANT applies the toggle, APPLY retires it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         ptr_reg   <= '0;
         win_reg   <= '0;
         gnt_reg   <= '0;
         ack_reg   <= '0;
         q_reg     <= '0;
         cnt_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               ack_reg <= '0;
               if (!hold && pick_valid) begin
                  gnt_reg   <= pick_onehot;
                  win_reg   <= pick_idx;
                  state_reg <= GRANT;
               end else begin
                  gnt_reg <= '0;
               end
            end
            GRANT: begin
               gnt_reg <= '0;
               // A requester that dropped its request before the toggle
               // forfeits the slot without moving the priority pointer.
               if (req[win_reg]) begin
                  q_reg     <= q_reg ^ mask_arr[win_reg];
                  ack_reg   <= gnt_reg;
                  state_reg <= APPLY;
               end else begin
                  state_reg <= IDLE;
               end
            end
            APPLY: begin
               ack_reg   <= '0;
               ptr_reg   <= (win_reg == LAST_IDX) ? '0 : win_reg + 1'b1;
               cnt_reg   <= sat_inc(cnt_reg);
               state_reg <= IDLE;
            end
            default: begin
               gnt_reg   <= '0;
               ack_reg   <= '0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign gnt     = gnt_reg;
   assign ack     = ack_reg;
   assign q       = q_reg;
   assign busy    = (state_reg != IDLE);
   assign tog_cnt = cnt_reg;

endmodule

// File: tb/tb_toggle_arbiter.sv
// Bench for toggle_arbiter: directed scenarios plus randomized transactions,
// checked against a transaction-level model of the arbitration rules.
module tb_toggle_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 8;

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] tmask;
   logic              hold;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   ack;
   logic [W-1:0]      q;
   logic              busy;
   logic [7:0]        tog_cnt;

   int n_vec  = 0;
   int n_miss = 0;

   // Reference model state
   int          ptr_m;
   logic [W-1:0] q_m;
   int          cnt_m;

   toggle_arbiter #(
      .NREQ (NREQ),
      .W    (W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .tmask   (tmask),
      .hold    (hold),
      .gnt     (gnt),
      .ack     (ack),
      .q       (q),
      .busy    (busy),
      .tog_cnt (tog_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Round-robin rule: first set request scanning ptr, ptr+1, ... mod NREQ.
   function automatic int pick(input logic [NREQ-1:0] r, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return 0;
   endfunction

   task automatic chk_all(input string tag, input logic [NREQ-1:0] eg,
                          input logic [NREQ-1:0] ea, input logic eb);
      chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
      chk({tag, "_ack"}, 32'(ack), 32'(ea));
      chk({tag, "_q"}, 32'(q), 32'(q_m));
      chk({tag, "_busy"}, 32'(busy), 32'(eb));
      chk({tag, "_cnt"}, 32'(tog_cnt), 32'(cnt_m));
   endtask

   task automatic do_reset(input string tag);
      #2 rst = 1'b0;
      #1;
      q_m   = '0;
      cnt_m = 0;
      ptr_m = 0;
      chk_all(tag, '0, '0, 1'b0);
      step();
      rst = 1'b1;
   endtask

   // One full transaction from IDLE; caller has set a nonzero req and hold=0.
   task automatic txn(input string tag, input bit withdraw, input bit remask, output int w);
      logic [NREQ-1:0] oh;
      w = pick(req, ptr_m);
      oh = '0;
      oh[w] = 1'b1;
      step();
      chk_all({tag, "_g"}, oh, '0, 1'b1);
      if (withdraw) begin
         req[w] = 1'b0;
         step();
         chk_all({tag, "_wd"}, '0, '0, 1'b0);
         $display("txn %s: winner=%0d withdrawn q=%h cnt=%0d", tag, w, q, tog_cnt);
         return;
      end
      if (remask) tmask = $urandom;
      q_m = q_m ^ tmask[w*W +: W];
      step();
      chk_all({tag, "_a"}, '0, oh, 1'b1);
      req[w] = 1'b0;
      step();
      cnt_m = (cnt_m == 255) ? 255 : cnt_m + 1;
      ptr_m = (w + 1) % NREQ;
      chk_all({tag, "_i"}, '0, '0, 1'b0);
      $display("txn %s: winner=%0d q=%h cnt=%0d", tag, w, q, tog_cnt);
   endtask

   initial begin
      int w;
      rst   = 1'b0;
      req   = '0;
      tmask = '0;
      hold  = 1'b0;
      q_m   = '0;
      cnt_m = 0;
      ptr_m = 0;

      // Reset state, before any clock edge
      #2;
      chk_all("reset", '0, '0, 1'b0);
      step();
      step();
      rst = 1'b1;

      // Single request with mask A5
      req   = 4'b0001;
      tmask = 32'h0000_00A5;
      txn("single", 1'b0, 1'b0, w);
      chk("single_q", 32'(q), 32'h0000_00A5);
      chk("single_cnt", 32'(tog_cnt), 32'd1);

      // Fairness: all requesting, each drops for one cycle after its ack
      do_reset("rst_fair");
      req   = 4'b1111;
      tmask = 32'h8040_2010;
      for (int i = 0; i < 5; i++) begin
         txn("fair", 1'b0, 1'b0, w);
         chk("fair_order", 32'(w), 32'(i % NREQ));
         req[w] = 1'b1;
      end
      chk("fair_cnt", 32'(tog_cnt), 32'd5);
      req = '0;
      step();

      // Reset during APPLY clears everything without a clock edge
      req   = 4'b0001;
      tmask = 32'h0000_00FF;
      step();
      step();
      chk("rstmid_ack_pre", 32'(ack), 32'h1);
      #2 rst = 1'b0;
      #1;
      q_m   = '0;
      cnt_m = 0;
      ptr_m = 0;
      chk_all("rstmid", '0, '0, 1'b0);
      req = '0;
      step();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_all("rstmid_post", '0, '0, 1'b0);
      end

      // Withdrawal: pointer must not advance
      req   = 4'b0010;
      tmask = 32'h0000_3C00;
      txn("wdraw", 1'b1, 1'b0, w);
      chk("wdraw_w", 32'(w), 32'd1);
      req = 4'b1010;
      txn("after_wd", 1'b0, 1'b0, w);
      chk("after_wd_w", 32'(w), 32'd1);
      req = '0;

      // Hold freezes arbitration
      hold = 1'b1;
      req  = 4'b0100;
      for (int i = 0; i < 10; i++) begin
         step();
         chk_all("hold", '0, '0, 1'b0);
      end
      hold = 1'b0;
      txn("unhold", 1'b0, 1'b0, w);
      chk("unhold_w", 32'(w), 32'd2);

      // Randomized transactions with occasional hold bursts and withdrawals
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            hold = 1'b1;
            req  = 4'($urandom_range(0, 15));
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
               step();
               chk_all("rhold", '0, '0, 1'b0);
            end
            hold = 1'b0;
         end
         req   = 4'($urandom_range(1, 15));
         tmask = $urandom;
         txn("rand", ($urandom_range(0, 3) == 0), 1'b1, w);
      end
      req = '0;

      // Saturation: 260 transactions toggling bit 0
      do_reset("rst_sat");
      for (int i = 0; i < 260; i++) begin
         req   = 4'b0001;
         tmask = {$urandom_range(0, 255) << 8} | 32'h01;
         tmask[7:0] = 8'h01;
         txn("sat", 1'b0, 1'b0, w);
      end
      chk("sat_cnt", 32'(tog_cnt), 32'd255);
      chk("sat_q", 32'(q), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
